mod_i2s_tx: RTL

//  Output stage downstream of mod_synth: accepts 32-bit signed samples on a ready pulse,

---
 rtl/mod_i2s_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mod_i2s_tx.sv
// I2S transmitter: sample FIFO, SCLK divider and frame serialiser with sticky overflow/underrun flags.
// Build option: define MOD_I2S_TX_STEREO_EN for two FIFO pops per frame (left, right); default is mono.
module mod_i2s_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCLK_DIV   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [31:0]                 i_sample,
  input  logic                        i_valid,
  input  logic                        i_enable,
  output logic                        o_fifo_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_sclk,
  output logic                        o_lrclk,
  output logic                        o_sdata,
  output logic                        o_overflow,
  output logic                        o_underrun
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int DIV_TC_I = SCLK_DIV - 1;
  localparam logic [DW-1:0] DIV_TC  = DIV_TC_I[DW-1:0];
  localparam logic [PW-1:0] DEPTH_L = FIFO_DEPTH[PW-1:0];
  localparam logic [PW-1:0] LVL_ONE = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_TAIL} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          ovf_q, ovf_d;
  logic          und_q, und_d;
  logic [31:0]   left_q, left_d;
  logic [31:0]   right_q, right_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   mem [FIFO_DEPTH];

  logic [PW-1:0] level;
  logic [31:0]   head0;
  logic [1:0]    pop_cnt;
  logic          push;
  logic          full_after_pop;
  logic          tick;
  logic          fall;
  logic [4:0]    idx;

  assign level = wr_q - rd_q;
  assign head0 = mem[rd_q[AW-1:0]];

`ifdef MOD_I2S_TX_STEREO_EN
  logic [AW-1:0] rd_nx;
  logic [31:0]   head1;
  assign rd_nx = rd_q[AW-1:0] + AW'(1);
  assign head1 = mem[rd_nx];
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    ovf_d   = ovf_q;
    und_d   = und_q;
    left_d  = left_q;
    right_d = right_q;
    pop_cnt = 2'd0;
    tick    = (state_q != S_IDLE) && (div_q == DIV_TC);
    fall    = tick && sclk_q;
    // Bit index within a slot: falling edge k carries bit (32 - k) mod 32 of the slot word.
    idx     = 5'd0 - bit_q[4:0];

    unique case (state_q)
      S_IDLE: begin
        sclk_d  = 1'b0;
        lrclk_d = 1'b1;
        sdata_d = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        if (i_enable) state_d = S_RUN;
      end
      default: begin
        if (state_q == S_RUN && !i_enable) state_d = S_DRAIN;
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
        end else begin
          div_d = div_q + DW'(1);
        end
        if (fall) begin
          bit_d = bit_q + 6'd1;
          if (state_q == S_TAIL) begin
            state_d = S_IDLE;
            sdata_d = 1'b0;
            bit_d   = '0;
          end else if (bit_q == 6'd0) begin
            // Frame edge: the previous right word's LSB goes out one bit late.
            sdata_d = right_q[0];
            if (state_q == S_DRAIN) begin
              state_d = S_TAIL;
              bit_d   = '0;
            end else begin
              lrclk_d = 1'b0;
`ifdef MOD_I2S_TX_STEREO_EN
              if (level > LVL_ONE) begin
                left_d  = head0;
                right_d = head1;
                pop_cnt = 2'd2;
              end else if (level == LVL_ONE) begin
                left_d  = head0;
                right_d = '0;
                pop_cnt = 2'd1;
                und_d   = 1'b1;
              end else begin
                left_d  = '0;
                right_d = '0;
                und_d   = 1'b1;
              end
`else
              if (level != '0) begin
                left_d  = head0;
                right_d = head0;
                pop_cnt = 2'd1;
              end else begin
                left_d  = '0;
                right_d = '0;
                und_d   = 1'b1;
              end
`endif
            end
          end else if (bit_q == 6'd32) begin
            lrclk_d = 1'b1;
            sdata_d = left_q[0];
          end else begin
            sdata_d = bit_q[5] ? right_q[idx] : left_q[idx];
          end
        end
      end
    endcase

    // A pop in the same cycle frees room before the write is considered.
    full_after_pop = (level == DEPTH_L) && (pop_cnt == 2'd0);
    push           = i_valid && !full_after_pop;
    if (i_valid && full_after_pop) ovf_d = 1'b1;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
      left_q  <= left_d;
      right_q <= right_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // NOTE: the sample storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem[wr_q[AW-1:0]] <= i_sample;
  end

  assign o_level      = level;
  assign o_fifo_ready = (level != DEPTH_L);
  assign o_sclk       = sclk_q;
  assign o_lrclk      = lrclk_q;
  assign o_sdata      = sdata_q;
  assign o_overflow   = ovf_q;
  assign o_underrun   = und_q;

endmodule
